// File: rtl/apb_image_loader.sv
// APB write master that packs a pixel stream into words and loads them into the
// CatRecognizer register file. Optional pixel checksum: define LOADER_CHECKSUM_EN.
module apb_image_loader #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_WORD = 3,
  parameter int MAX_WORDS       = 4096,
  parameter int CTRL_ADDR       = 0,
  parameter int BASE_ADDR       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_WORDS):0]    num_words,
  input  logic                          pix_valid,
  input  logic [PIXEL_WIDTH-1:0]        pix_data,
  output logic                          pix_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  output logic [AMBA_WORD-1:0]          PWDATA,
  input  logic                          PREADY,
  output logic [15:0]                   checksum
);

  localparam int NW  = $clog2(MAX_WORDS) + 1;
  localparam int PCW = $clog2(PIXELS_PER_WORD + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FILL, S_WR, S_GO, S_DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_POST} phase_t;

  state_t                     state_q, state_d;
  phase_t                     phase_q, phase_d;
  logic [NW-1:0]              num_q, num_d;
  logic [NW-1:0]              word_idx_q, word_idx_d;
  logic [PCW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [AMBA_WORD-1:0]       pack_q, pack_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic                       pix_ready_q, pix_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic start_ok;
  logic accept;

  assign start_ok = start && (num_words != '0) && (num_words <= NW'(MAX_WORDS));
  assign accept   = pix_valid && pix_ready_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    num_d       = num_q;
    word_idx_d  = word_idx_q;
    pix_cnt_d   = pix_cnt_q;
    pack_d      = pack_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pix_ready_d = pix_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d    = S_CLR;
          num_d      = num_words;
          word_idx_d = '0;
          pix_cnt_d  = '0;
          busy_d     = 1'b1;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          phase_d    = PH_SETUP;
          paddr_d    = AMBA_ADDR_WIDTH'(CTRL_ADDR);
          pwdata_d   = '0;
        end
      end

      S_FILL: begin
        if (accept) begin
          pack_d = {pack_q[AMBA_WORD-PIXEL_WIDTH-1:0], pix_data};
          if (pix_cnt_q == PCW'(PIXELS_PER_WORD - 1)) begin
            pix_cnt_d   = '0;
            pix_ready_d = 1'b0;
            state_d     = S_WR;
            psel_d      = 1'b1;
            penable_d   = 1'b0;
            phase_d     = PH_SETUP;
            paddr_d     = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(word_idx_q);
            pwdata_d    = pack_d;
          end else begin
            pix_cnt_d = pix_cnt_q + PCW'(1);
          end
        end
      end

      // CLR, WR and GO share one APB sequencer: setup, access (held on
      // PREADY low), then one idle cycle before the next state is chosen.
      S_CLR, S_WR, S_GO: begin
        case (phase_q)
          PH_SETUP: begin
            penable_d = 1'b1;
            phase_d   = PH_ACCESS;
          end
          PH_ACCESS: begin
            if (PREADY) begin
              psel_d    = 1'b0;
              penable_d = 1'b0;
              phase_d   = PH_POST;
              if (state_q == S_WR) word_idx_d = word_idx_q + NW'(1);
            end
          end
          default: begin
            case (state_q)
              S_CLR: begin
                state_d     = S_FILL;
                pix_ready_d = 1'b1;
              end
              S_WR: begin
                if (word_idx_q == num_q) begin
                  state_d   = S_GO;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  phase_d   = PH_SETUP;
                  paddr_d   = AMBA_ADDR_WIDTH'(CTRL_ADDR);
                  pwdata_d  = AMBA_WORD'(1);
                end else begin
                  state_d     = S_FILL;
                  pix_ready_d = 1'b1;
                end
              end
              default: state_d = S_DONE;
            endcase
          end
        endcase
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    pwrite_d = psel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_SETUP;
      num_q       <= '0;
      word_idx_q  <= '0;
      pix_cnt_q   <= '0;
      pack_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      num_q       <= num_d;
      word_idx_q  <= word_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      pack_q      <= pack_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && start_ok) csum_d = '0;
    else if (accept)                   csum_d = csum_q + 16'(pix_data);
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_apb_image_loader.sv
// Directed + randomized bench for apb_image_loader; expected APB write sequence
// is derived from the pixel list (CTRL<-0, packed words, CTRL<-1).
module tb_apb_image_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] num_words;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:0] PADDR;
  logic [23:0] PWDATA;
  logic        PREADY;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  apb_image_loader #(
    .AMBA_WORD(24), .AMBA_ADDR_WIDTH(20), .PIXEL_WIDTH(8), .PIXELS_PER_WORD(3),
    .MAX_WORDS(4096), .CTRL_ADDR(0), .BASE_ADDR(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .busy(busy), .done(done), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .checksum(checksum)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // pixel source: holds a pixel until it is taken
  int feed_q[$];
  bit pending = 1'b0;
  int accepted = 0;
  initial begin
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pending && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        accepted++;
      end
      if (feed_q.size() > 0) begin
        pix_valid = 1'b1;
        pix_data  = 8'(feed_q[0]);
      end else begin
        pix_valid = 1'b0;
      end
      pending = pix_valid && pix_ready;
    end
  end

  // PREADY: 0 = always ready, 1 = random stalls, 2 = five stalls on address 2
  int rmode = 0;
  int stall_cnt = 0;
  initial begin
    PREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: PREADY = ($urandom_range(0, 3) != 0);
        2: begin
          if (PSEL && PENABLE && PADDR == 20'd2 && stall_cnt < 5) begin
            PREADY = 1'b0;
            stall_cnt++;
          end else begin
            PREADY = 1'b1;
          end
        end
        default: PREADY = 1'b1;
      endcase
    end
  end

  // APB observer
  logic [19:0] got_a[$];
  logic [23:0] got_d[$];
  int done_cnt = 0;
  int viol = 0;
  int en2_cnt = 0;
  bit in_xfer = 1'b0;
  logic [19:0] pa;
  logic [23:0] pd;
  always @(negedge clk) begin
    if (!rst && PSEL && PENABLE && PREADY) begin
      got_a.push_back(PADDR);
      got_d.push_back(PWDATA);
    end
    if (done) done_cnt++;
    if (PENABLE && !PSEL) viol++;
    if (PSEL && pix_ready) viol++;
    if (PSEL && !PWRITE) viol++;
    if (in_xfer && PSEL && (PADDR !== pa || PWDATA !== pd)) viol++;
    if (PSEL && PENABLE && PADDR == 20'd2) en2_cnt++;
    in_xfer = PSEL && !(PENABLE && PREADY);
    pa = PADDR;
    pd = PWDATA;
  end

  // reference model
  int img[$];
  logic [19:0] exp_a[$];
  logic [23:0] exp_d[$];
  logic [15:0] exp_csum;

  task automatic build_exp(input int nw);
    int s;
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(20'd0);
    exp_d.push_back(24'd0);
    for (int w = 0; w < nw; w++) begin
      exp_a.push_back(20'((1 + w) % (1 << 20)));
      exp_d.push_back(24'(img[3*w] * 65536 + img[3*w+1] * 256 + img[3*w+2]));
    end
    exp_a.push_back(20'd0);
    exp_d.push_back(24'd1);
    s = 0;
    foreach (img[i]) s += img[i];
`ifdef LOADER_CHECKSUM_EN
    exp_csum = 16'(s % 65536);
`else
    exp_csum = 16'd0;
`endif
  endtask

  task automatic run_load(input string tag, input int nw, input int budget,
                          input int poke, output int lat);
    int t0;
    bit seen;
    int mism;
    build_exp(nw);
    foreach (img[i]) feed_q.push_back(img[i]);
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    start = 1'b1;
    num_words = 13'(nw);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (i == poke) begin
        start = 1'b1;
        num_words = 13'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    lat = cyc - t0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, 64'(done), 64'd0);
    check({tag, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
    mism = 0;
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i >= got_a.size() || got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) mism++;
    end
    check({tag, "_write_mismatches"}, 64'(mism), 64'd0);
    check({tag, "_checksum"}, 64'(checksum), 64'(exp_csum));
  endtask

  initial begin
    int lat;
    int dc0;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a word
    feed_q.push_back(8'hAA);
    feed_q.push_back(8'hBB);
    start = 1'b1;
    num_words = 13'd1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (accepted >= 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midfill_two_pixels_taken", 64'(ok), 64'd1);
    check("midfill_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midfill_rst_psel", 64'(PSEL), 64'd0);
    check("midfill_rst_penable", 64'(PENABLE), 64'd0);
    check("midfill_rst_busy", 64'(busy), 64'd0);
    check("midfill_rst_pix_ready", 64'(pix_ready), 64'd0);
    rst = 1'b0;
    feed_q.delete();
    @(negedge clk);

    img = '{8'h11, 8'h22, 8'h33};
    run_load("one_word", 1, 200, -1, lat);
    check("one_word_latency", 64'(lat), 64'd14);
    check("one_word_data_addr", 64'(got_a.size() > 1 ? got_a[1] : 20'hFFFFF), 64'd1);
    check("one_word_data", 64'(got_d.size() > 1 ? got_d[1] : 24'hFFFFFF), 64'h112233);

    // four words, PREADY tied high
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(i);
    run_load("four_words", 4, 200, -1, lat);
    check("four_words_latency", 64'(lat), 64'd32);
    check("four_words_w4", 64'(got_d.size() > 4 ? got_d[4] : 24'hFFFFFF), 64'h090A0B);

    // five-cycle stall on the second data write
    img.delete();
    for (int i = 0; i < 9; i++) img.push_back($urandom_range(0, 255));
    en2_cnt = 0;
    stall_cnt = 0;
    rmode = 2;
    run_load("stall", 3, 300, -1, lat);
    rmode = 0;
    check("stall_penable_cycles", 64'(en2_cnt), 64'd6);
    check("stall_latency", 64'(lat), 64'd31);

    // starts that must be ignored
    dc0 = done_cnt;
    got_a.delete();
    foreach (num_words[i]) num_words[i] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    num_words = 13'd0;
    @(negedge clk);
    start = 1'b1;
    num_words = 13'd4097;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("ignored_start_writes", 64'(got_a.size()), 64'd0);
    check("ignored_start_busy", 64'(busy), 64'd0);
    check("ignored_start_done_cnt", 64'(done_cnt), 64'(dc0));

    img.delete();
    for (int i = 0; i < 6; i++) img.push_back($urandom_range(0, 255));
    dc0 = done_cnt;
    run_load("start_while_busy", 2, 300, 5, lat);
    repeat (12) @(negedge clk);
    check("start_while_busy_extra_writes", 64'(got_a.size()), 64'd4);
    check("start_while_busy_done_cnt", 64'(done_cnt), 64'(dc0 + 1));
    check("start_while_busy_idle", 64'(busy), 64'd0);

    // three 0xFF pixels
    img = '{8'hFF, 8'hFF, 8'hFF};
    run_load("csum_ff", 1, 200, -1, lat);
`ifdef LOADER_CHECKSUM_EN
    check("csum_ff_value", 64'(checksum), 64'h02FD);
`else
    check("csum_ff_value", 64'(checksum), 64'h0000);
`endif

    // full-size image with random PREADY stalls
    img.delete();
    for (int i = 0; i < 12288; i++) img.push_back($urandom_range(0, 255));
    rmode = 1;
    run_load("full", 4096, 80000, -1, lat);
    rmode = 0;
    check("full_last_data_addr", 64'(got_a.size() >= 4098 ? got_a[4096] : 20'hFFFFF), 64'd4096);
    check("full_final_addr", 64'(got_a.size() >= 4098 ? got_a[4097] : 20'hFFFFF), 64'd0);
    check("full_final_data", 64'(got_d.size() >= 4098 ? got_d[4097] : 24'hFFFFFF), 64'd1);

    repeat (3) @(negedge clk);
    check("apb_protocol_violations", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_image_loader.md
Name: apb_image_loader

Overview:
Synthesizable APB write master that replaces bench-driven register loading for CatRecognizer.
- Accepts a pixel byte stream and packs PIXELS_PER_WORD pixels per APB word.
- Writes the words to consecutive register addresses, then writes the start_work bit to the control register.
- Adds a PREADY wait-state handshake, run-time image-length selection and a completion pulse.
- Sits between the image source (DMA/host stream) and the CatRecognizer APB slave.

Parameters:
AMBA_WORD, 24, APB data width (bits)
AMBA_ADDR_WIDTH, 20, APB address width (bits)
PIXEL_WIDTH, 8, bits per pixel; AMBA_WORD must equal PIXEL_WIDTH*PIXELS_PER_WORD
PIXELS_PER_WORD, 3, pixels packed per APB word
MAX_WORDS, 4096, maximum image length in words (12288 pixels / 3)
CTRL_ADDR, 0, control register address; bit0 = start_work
BASE_ADDR, 1, address of first image word

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to load one image
num_words  in  log2(MAX_WORDS)+1  words to load; sampled on accepted start
pix_valid  in  1  pixel strobe
pix_data  in  PIXEL_WIDTH  pixel value
pix_ready  out  1  loader accepts pixel this cycle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after start_work write completes
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write (only writes issued)
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PREADY  in  1  slave ready; ends access phase
checksum  out  16  pixel sum (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; pack buffer, pixel count and word count cleared. Reset mid-transfer drops PSEL/PENABLE on the next edge and discards any partial word.
- States:
  - IDLE: start=1 with num_words in 1..MAX_WORDS → CLR. Latch num_words. busy=1 from the next cycle.
  - IDLE: start with num_words=0 or >MAX_WORDS is ignored.
  - IDLE: pixels arriving are not accepted (pix_ready=0).
  - CLR: APB write of data 0 to CTRL_ADDR, so the recognizer stops before its registers are overwritten → FILL.
  - FILL: pix_ready=1. Each pix_valid&pix_ready cycle shifts the pixel in. First pixel of a word lands in the MSBs, i.e. word = {p0,p1,p2}. After PIXELS_PER_WORD pixels → WR; pix_ready=0 on the following cycle.
  - WR: APB write of the packed word to BASE_ADDR+word_idx; word_idx increments when the access completes. If word_idx == num_words after the increment → GO, else → FILL.
  - GO: APB write of data 1 to CTRL_ADDR → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- APB transfer (CLR/WR/GO):
  - Setup cycle: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid.
  - Access phase: PENABLE=1, held while PREADY=0. Transfer completes on the first edge with PSEL&PENABLE&PREADY.
  - Next cycle PSEL=0, PENABLE=0. Back-to-back transfers therefore take at least 3 cycles each.
  - PADDR/PWDATA stay stable from setup through completion.
- Minimum latency, PREADY tied high: 3 (CLR) + num_words*(PIXELS_PER_WORD+3) + 3 (GO) + 1 cycles from start to done.
- Address wrap: BASE_ADDR+word_idx computed at AMBA_ADDR_WIDTH and wraps modulo 2^AMBA_ADDR_WIDTH. With the default parameters no wrap occurs.
- start while busy is ignored; no queuing.
- pix_valid held during WR is not consumed. The source holds the pixel until pix_ready.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: checksum accumulates every accepted pixel, zero-extended, modulo 2^16. It clears on accepted start and holds its value after done.
- Undefined: checksum is tied to 0 and no accumulator logic is generated.

Test Plan:
- Reset during FILL after 2 pixels, PREADY=1 → PSEL/PENABLE=0 next cycle, busy=0. A new start with num_words=1 and pixels 0x11,0x22,0x33 gives APB writes (0,0x000000), (1,0x112233), (0,0x000001), then done.
- num_words=4, pixels 0..11, PREADY=1 → data writes to addresses 1..4 with 0x000102, 0x030405, 0x060708, 0x090A0B. done exactly 32 cycles after start.
- PREADY low 5 cycles on the 2nd data write → PENABLE held 6 cycles, PADDR=2/PWDATA stable, pix_ready=0 throughout, no pixel lost.
- start with num_words=0, and start pulsed while busy → no APB activity from either, busy unchanged, done count unchanged.
- num_words=4096 full image with random PREADY stalls → 4098 writes; last data write to address 4096; final write to CTRL_ADDR with data 1.
- LOADER_CHECKSUM_EN defined, 3 pixels 0xFF → checksum=0x02FD after done. Macro undefined → checksum=0.
